// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic {
    MST0 = 1'b0,
    MST1 = 1'b1
  } master_e;

  function automatic master_e other(input master_e m);
    return (m == MST0) ? MST1 : MST0;
  endfunction

endpackage

// File: rtl/owner_fifo.sv
// 1-bit synchronous FIFO recording which master owns each outstanding read.
module owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q, count_d;
  logic [DEPTH-1:0] mem_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one pipelined memory port between two masters,
// with in-order read response routing through an owner FIFO.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW    = 30,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic [AW-1:0] m0_address,
  input  logic          m0_read,
  input  logic          m0_write,
  input  logic [1:0]    m0_id,
  input  logic [31:0]   m0_writedata,
  input  logic [3:0]    m0_writedatamask,
  output logic          m0_waitrequest,
  output logic [31:0]   m0_readdata,
  output logic [1:0]    m0_readdataid,
  input  logic [AW-1:0] m1_address,
  input  logic          m1_read,
  input  logic          m1_write,
  input  logic [1:0]    m1_id,
  input  logic [31:0]   m1_writedata,
  input  logic [3:0]    m1_writedatamask,
  output logic          m1_waitrequest,
  output logic [31:0]   m1_readdata,
  output logic [1:0]    m1_readdataid,
  output logic [AW-1:0] s_address,
  output logic          s_read,
  output logic          s_write,
  output logic [1:0]    s_id,
  output logic [31:0]   s_writedata,
  output logic [3:0]    s_writedatamask,
  input  logic          s_waitrequest,
  input  logic [31:0]   s_readdata,
  input  logic [1:0]    s_readdataid,
  output logic          err
);

  master_e last_q, last_d, win;
  logic    act0, act1, win_act, win_rd, win_wr, blocked, accept;
  logic    fifo_full, fifo_empty, fifo_head, rsp_valid;
  logic    err_q, err_d;

  // Gating with rst_n keeps the request path quiet while reset is held.
  assign act0    = rst_n && (m0_read || m0_write);
  assign act1    = rst_n && (m1_read || m1_write);
  assign win_act = act0 || act1;

  always_comb begin
    win = MST0;
    if (act0 && act1) begin
      win = other(last_q);
    end else if (act1) begin
      win = MST1;
    end
  end

  always_comb begin
    s_address       = m0_address;
    s_id            = m0_id;
    s_writedata     = m0_writedata;
    s_writedatamask = m0_writedatamask;
    win_rd          = win_act && m0_read;
    win_wr          = win_act && m0_write;
    if (win == MST1) begin
      s_address       = m1_address;
      s_id            = m1_id;
      s_writedata     = m1_writedata;
      s_writedatamask = m1_writedatamask;
      win_rd          = win_act && m1_read;
      win_wr          = win_act && m1_write;
    end
  end

  // A full owner FIFO stalls the winning read and everything behind it.
  assign blocked = win_rd && fifo_full;
  assign s_read  = win_rd && !blocked;
  assign s_write = win_wr && !blocked;
  assign accept  = win_act && !s_waitrequest && !blocked;

  assign m0_waitrequest = !(act0 && (win == MST0)) || s_waitrequest || blocked;
  assign m1_waitrequest = !(act1 && (win == MST1)) || s_waitrequest || blocked;

  assign last_d = accept ? win : last_q;

  assign rsp_valid     = (s_readdataid != 2'd0);
  assign m0_readdata   = s_readdata;
  assign m1_readdata   = s_readdata;
  assign m0_readdataid = (rsp_valid && !fifo_empty && !fifo_head) ? s_readdataid : 2'd0;
  assign m1_readdataid = (rsp_valid && !fifo_empty &&  fifo_head) ? s_readdataid : 2'd0;

  assign err_d = err_q || (rsp_valid && fifo_empty);
  assign err   = err_q;

  owner_fifo #(.DEPTH(DEPTH)) u_owner_fifo (
    .clk   (clock),
    .rst_n (rst_n),
    .push  (accept && win_rd),
    .pop   (rsp_valid),
    .din   (win == MST1),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= MST1;
      err_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      err_q  <= err_d;
    end
  end

endmodule
